// File: rtl/sccb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sccb_arbiter_pkg
// Shared definitions for the SCCB write arbiter:
//   - SCCB field widths (register address / register data)
//   - FSM state encodings (3-bit, kept as plain constants for legacy tools)
//   - clog2 helper used to size pointers and the watchdog timer
// -----------------------------------------------------------------------------
package sccb_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sccb_arbiter_if.sv
// -----------------------------------------------------------------------------
// sccb_arbiter_if
// Bus between the arbiter and the single SCCB master engine.
//   sccb_start : one-cycle start pulse towards the engine
//   sccb_addr  : register address for the transaction
//   sccb_data  : register data for the transaction
//   sccb_ready : engine idle flag (low while a transfer is on the wire)
// Modports:
//   master : arbiter side (drives start/addr/data, samples ready)
//   slave  : engine side  (samples start/addr/data, drives ready)
// -----------------------------------------------------------------------------
interface sccb_arbiter_if;
  import sccb_arbiter_pkg::*;

  logic              sccb_start;
  logic              sccb_ready;
  logic [ADDR_W-1:0] sccb_addr;
  logic [DATA_W-1:0] sccb_data;

  modport master (
    output sccb_start,
    output sccb_addr,
    output sccb_data,
    input  sccb_ready
  );

  modport slave (
    input  sccb_start,
    input  sccb_addr,
    input  sccb_data,
    output sccb_ready
  );

endinterface

// File: rtl/sccb_rr_picker.sv
// -----------------------------------------------------------------------------
// sccb_rr_picker
// Combinational round-robin winner selection.
// Ports:
//   req_i    : request vector
//   ptr_i    : index with highest priority this round
//   valid_o  : at least one request is pending
//   idx_o    : winner index
//   onehot_o : winner as a one-hot vector (0 when no request)
// -----------------------------------------------------------------------------
module sccb_rr_picker
  import sccb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic [NUM_REQ-1:0] onehot_o
);

  logic [NUM_REQ-1:0] upper;
  logic [NUM_REQ-1:0] src;

  always_comb begin
    // Requests at or above the pointer win first; if there are none the
    // search wraps to the lowest set bit of the full vector.
    upper = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      upper[j] = req_i[j] && (j >= int'(ptr_i));
    end
    src     = (|upper) ? upper : req_i;
    valid_o = |req_i;
    idx_o   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (src[j]) idx_o = PTR_W'(j);
    end
    // Isolate the lowest set bit.
    onehot_o = src & ~(src - 1'b1);
  end

endmodule

// File: rtl/sccb_arbiter.sv
// -----------------------------------------------------------------------------
// sccb_arbiter
// Shares one SCCB master between NUM_REQ register-write requesters.
// Round-robin grant, one-cycle start, tracks the engine's ready low/high
// cycle, returns a one-cycle ack to the winner, and releases the bus with
// err when a transaction exceeds WATCHDOG_CYC enabled cycles.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   clk_en            : all state advances only when high
//   req               : per-requester write request (held until ack)
//   req_addr/req_data : 8-bit slice i belongs to requester i
//   ack               : one-cycle completion pulse to the winner
//   grant             : one-hot bus owner, 0 when idle
//   err               : watchdog expiry, coincident with ack
//   busy              : FSM not in IDLE
//   bus               : SCCB master engine (master modport)
// -----------------------------------------------------------------------------
module sccb_arbiter
  import sccb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int WATCHDOG_CYC = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      err,
  output logic                      busy,
  sccb_arbiter_if.master            bus
);

  localparam int PTR_W = clog2(NUM_REQ);
  localparam int TMR_W = clog2(WATCHDOG_CYC) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WATCHDOG_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  logic [2:0]         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [TMR_W-1:0]   timer_q, timer_d, timer_inc;
  logic               wd_q, wd_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;

  logic               pick_valid;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  sccb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx),
    .onehot_o (pick_onehot)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    timer_d   = timer_q;
    wd_d      = wd_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ack_d     = '0;
    err_d     = 1'b0;
    start_d   = 1'b0;
    timer_inc = timer_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.sccb_ready && pick_valid) begin
          addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          data_d  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
          grant_d = pick_onehot;
          owner_d = pick_idx;
          start_d = 1'b1;
          busy_d  = 1'b1;
          timer_d = '0;
          wd_d    = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        // Watchdog is checked first so it wins over a same-cycle ready edge;
        // the timer stops at WATCHDOG_CYC-1 and therefore never wraps.
        timer_d = timer_inc;
        if (timer_inc == TMR_LAST) begin
          wd_d    = 1'b1;
          state_d = ST_ACK;
        end else if (state_q == ST_WAIT_BUSY && !bus.sccb_ready) begin
          state_d = ST_WAIT_DONE;
        end else if (state_q == ST_WAIT_DONE && bus.sccb_ready) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_d   = grant_q;
        err_d   = wd_q;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      timer_q <= '0;
      wd_q    <= 1'b0;
      ack_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (clk_en) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      timer_q <= timer_d;
      wd_q    <= wd_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign ack            = ack_q;
  assign grant          = grant_q;
  assign err            = err_q;
  assign busy           = busy_q;
  assign bus.sccb_start = start_q;
  assign bus.sccb_addr  = addr_q;
  assign bus.sccb_data  = data_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sccb_arbiter
// Self-checking bench for sccb_arbiter (NUM_REQ=3, WATCHDOG_CYC=16).
// A transaction-level reference model predicts every output each cycle from
// the round-robin, latency and watchdog rules; an SCCB engine emulator
// answers start pulses with a ready low/high cycle (or hangs). Directed
// scenarios are followed by randomized requesters, clk_en gating and resets.
// -----------------------------------------------------------------------------
module tb_sccb_arbiter;
  import sccb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int WD = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           clk_en = 1'b1;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_addr = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack, grant;
  logic           err, busy;

  sccb_arbiter_if bus_if ();

  sccb_arbiter #(
    .NUM_REQ      (N),
    .WATCHDOG_CYC (WD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .grant    (grant),
    .err      (err),
    .busy     (busy),
    .bus      (bus_if.master)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] e_ack = '0, e_grant = '0;
  logic         e_err = 1'b0, e_busy = 1'b0, e_start = 1'b0;
  logic [7:0]   e_addr = '0, e_data = '0;
  int  m_own = -1;   // current owner, -1 when the bus is free
  int  m_ptr = 0;
  int  m_el = 0;     // enabled edges since the start pulse appeared
  bit  m_low = 0;    // engine has been seen busy
  bit  m_fin = 0;    // completion decided; ack goes out on the next edge
  bit  m_fin_err = 0;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e_ack = '0; e_grant = '0; e_err = 0; e_busy = 0; e_start = 0;
      e_addr = '0; e_data = '0; m_own = -1; m_ptr = 0;
    end else if (clk_en) begin
      e_ack = '0; e_err = 0; e_start = 0;
      if (m_own < 0) begin
        if (bus_if.sccb_ready && req != '0) begin
          m_own = rr_pick(req, m_ptr);
          m_el = 0; m_low = 0; m_fin = 0; m_fin_err = 0;
          e_grant = '0; e_grant[m_own] = 1'b1;
          e_start = 1; e_busy = 1;
          e_addr = req_addr[m_own*8 +: 8];
          e_data = req_data[m_own*8 +: 8];
        end
      end else begin
        m_el++;
        if (m_fin) begin
          e_ack[m_own] = 1'b1; e_err = m_fin_err;
          e_grant = '0; e_busy = 0;
          m_ptr = (m_own + 1) % N; m_own = -1;
        end else if (m_el >= 2) begin
          // edge m_el is the (m_el-1)-th edge spent watching the bus
          if (m_el == WD) begin m_fin = 1; m_fin_err = 1; end
          else if (!m_low) begin if (!bus_if.sccb_ready) m_low = 1; end
          else if (bus_if.sccb_ready) m_fin = 1;
        end
      end
    end
  end

  // ---------------- stimulus state ----------------
  int  cyc = 0, rise_cyc = 0, n_start = 0;
  bit  trig = 0;
  int  drop_in = -1, low_left = 0, low_len = 1;
  int  fixed_dly = 2, fixed_low = 6, bus_mode_force = 0;
  bit  glitch_en = 0, auto_req = 0, rst_rand = 0;
  int  en_mode = 0;

  always @(posedge clk) begin
    if (!rst && clk_en && bus_if.sccb_start) trig = 1;
  end

  task automatic bus_tick();
    int m, r;
    if (trig) begin
      trig = 0;
      r = int'($urandom_range(0, 99));
      m = (bus_mode_force >= 0) ? bus_mode_force : (r < 8 ? 1 : (r < 14 ? 2 : 0));
      low_len = (fixed_low > 0) ? fixed_low : int'($urandom_range(1, 8));
      if (m == 2) low_len = 3 * WD;
      drop_in = (m == 1) ? -1 : ((fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3)));
    end
    if (drop_in == 0) begin
      bus_if.sccb_ready = 1'b0; low_left = low_len; drop_in = -1;
    end else if (drop_in > 0) begin
      drop_in--;
    end else if (low_left > 0) begin
      low_left--;
      if (low_left == 0) begin bus_if.sccb_ready = 1'b1; rise_cyc = cyc; end
    end else if (glitch_en && bus_if.sccb_ready && $urandom_range(0, 19) == 0) begin
      bus_if.sccb_ready = 1'b0; low_left = int'($urandom_range(1, 4));
    end
  endtask

  task automatic req_tick();
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
          req_addr[i*8 +: 8] = 8'($urandom); req_data[i*8 +: 8] = 8'($urandom);
        end else if ($urandom_range(0, 49) == 0) begin
          req[i] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          req_addr[i*8 +: 8] = 8'($urandom); req_data[i*8 +: 8] = 8'($urandom);
        end
      end else if ($urandom_range(0, 4) == 0) begin
        req[i] = 1'b1;
        req_addr[i*8 +: 8] = 8'($urandom); req_data[i*8 +: 8] = 8'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    chk("ack", ack, e_ack);
    chk("grant", grant, e_grant);
    chk("err", err, e_err);
    chk("busy", busy, e_busy);
    chk("start", bus_if.sccb_start, e_start);
    chk("addr", bus_if.sccb_addr, e_addr);
    chk("data", bus_if.sccb_data, e_data);
    if (bus_if.sccb_start) n_start++;
    bus_tick();
    if (auto_req) req_tick();
    case (en_mode)
      1:       clk_en = (cyc % 4 == 0);
      2:       clk_en = ($urandom_range(0, 9) < 7);
      default: clk_en = 1'b1;
    endcase
    if (rst_rand) rst = ($urandom_range(0, 199) == 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy && ack == '0 && drop_in < 0 && low_left == 0 && bus_if.sccb_ready) break;
      tick();
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  logic [N-1:0] g [3];
  logic [7:0]   a [3];
  int k, r0, s0;

  initial begin
    bus_if.sccb_ready = 1'b1;
    g[0] = '0; g[1] = '0; g[2] = '0;
    a[0] = '0; a[1] = '0; a[2] = '0;

    // Single request
    do_reset();
    fixed_dly = 2; fixed_low = 10; n_start = 0;
    req_addr[7:0] = 8'h12; req_data[7:0] = 8'h80; req = 3'b001;
    for (int i = 0; i < 100; i++) begin tick(); if (ack != '0) break; end
    chk("single_ack", ack, 3'b001);
    chk("single_err", err, 1'b0);
    chk("single_starts", n_start, 1);
    chk("single_ack_lat", cyc - rise_cyc, 2);
    chk("single_addr", bus_if.sccb_addr, 8'h12);
    chk("single_data", bus_if.sccb_data, 8'h80);
    req = '0;

    // Contention right after reset: 0, 1, 0
    wait_idle();
    do_reset();
    fixed_dly = 1; fixed_low = 3; k = 0;
    req_addr[7:0] = 8'h3A; req_addr[15:8] = 8'h40; req = 3'b011;
    for (int i = 0; i < 200 && k < 3; i++) begin
      tick();
      if (bus_if.sccb_start) begin g[k] = grant; a[k] = bus_if.sccb_addr; k++; end
    end
    chk("rr_first", g[0], 3'b001);
    chk("rr_second", g[1], 3'b010);
    chk("rr_third", g[2], 3'b001);
    chk("rr_first_addr", a[0], 8'h3A);
    chk("rr_second_addr", a[1], 8'h40);
    req = '0;

    // Ready low at request time
    wait_idle();
    bus_if.sccb_ready = 1'b0; req = 3'b010; n_start = 0;
    repeat (5) tick();
    chk("rdylow_nostart", n_start, 0);
    bus_if.sccb_ready = 1'b1; r0 = cyc;
    for (int i = 0; i < 10; i++) begin tick(); if (bus_if.sccb_start) break; end
    chk("rdylow_start_lat", cyc - r0, 1);
    chk("rdylow_grant", grant, 3'b010);
    for (int i = 0; i < 100; i++) begin tick(); if (ack != '0) break; end
    chk("rdylow_ack", ack, 3'b010);
    req = '0;

    // Watchdog: engine never drops ready
    wait_idle();
    bus_mode_force = 1; req = 3'b100; s0 = cyc;
    for (int i = 0; i < 20; i++) begin tick(); if (bus_if.sccb_start) break; end
    s0 = cyc;
    for (int i = 0; i < 60; i++) begin tick(); if (ack != '0) break; end
    chk("wd_ack", ack, 3'b100);
    chk("wd_err", err, 1'b1);
    chk("wd_lat", cyc - s0, WD + 1);
    req = '0;
    tick();
    chk("wd_grant_clear", grant, 3'b000);
    chk("wd_busy_clear", busy, 1'b0);
    bus_mode_force = 0;

    // clk_en 1-of-4
    wait_idle();
    en_mode = 1; fixed_dly = 2; fixed_low = 6; req = 3'b001;
    for (int i = 0; i < 400; i++) begin tick(); if (ack != '0) break; end
    chk("gated_ack", ack, 3'b001);
    chk("gated_err", err, 1'b0);
    req = '0; en_mode = 0;

    // Reset while waiting for the engine to finish
    wait_idle();
    fixed_dly = 0; fixed_low = 8; req = 3'b001;
    for (int i = 0; i < 30; i++) begin tick(); if (!bus_if.sccb_ready) break; end
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_grant", grant, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack", ack, 3'b000);
    n_start = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (ack != '0) break; end
    chk("reserve_starts", n_start, 1);
    chk("reserve_ack", ack, 3'b001);
    req = '0;

    // Randomized traffic
    wait_idle();
    fixed_dly = -1; fixed_low = -1; bus_mode_force = -1;
    glitch_en = 1; auto_req = 1;
    repeat (1500) tick();
    en_mode = 2;
    repeat (1500) tick();
    en_mode = 0; rst_rand = 1;
    repeat (1500) tick();
    rst_rand = 0; rst = 1'b0; auto_req = 0; req = '0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
